// File: rtl/cpu_mem_responder_pkg.sv
// Shared constants for cpu_mem_responder: FSM encoding, default latency, and LFSR constants
// used by the optional response-stall mode (RESP_STALL_EN).
package cpu_mem_responder_pkg;

    localparam int unsigned LAT_DEFAULT = 2;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned LFSR_W      = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_WAIT   = 4'b0010,
        S_RESP_I = 4'b0100,
        S_RESP_D = 4'b1000
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port 32-bit word RAM with byte-strobed synchronous write and read-first registered read.
// A combinational peek of the addressed word serves single-cycle-latency captures.
module mem_word_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    strb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [31:0]   peek_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = mem[addr];
    end

    assign peek_c = mem[addr];
    assign rdata  = rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && strb[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU fetch/data channels: one outstanding read, fixed LAT latency.
// Define RESP_STALL_EN to add LFSR-driven extra latency and ready gating for handshake stress.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LAT        = LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    is_inst_q, is_inst_d;
    logic                    inst_valid_q, inst_valid_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [31:0]             instruction_q, instruction_d;
    logic [31:0]             read_data_q, read_data_d;

    logic                    idle;
    logic                    gate_ok;
    logic [1:0]              extra_lat;
    logic                    store_acc, load_acc, fetch_acc;
    logic [ADDR_WIDTH-1:0]   req_idx, ram_addr;
    logic [CNT_W-1:0]        total_lat;
    logic [31:0]             ram_rdata, ram_peek;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef RESP_STALL_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gate_ok   = ~lfsr_q[2];
    assign extra_lat = lfsr_q[1:0];
`else
    assign gate_ok   = 1'b1;
    assign extra_lat = 2'd0;
`endif

    // Request acceptance; data side has priority and a store masks a simultaneous load
    always_comb begin
        idle           = (state_q == S_IDLE);
        Mem_Req_Ready  = idle & ~rst & gate_ok;
        Inst_Req_Ready = Mem_Req_Ready & ~MemRead & ~MemWrite;
        store_acc      = MemWrite & Mem_Req_Ready;
        load_acc       = MemRead & ~MemWrite & Mem_Req_Ready;
        fetch_acc      = Inst_Req_Valid & Inst_Req_Ready;
        req_idx        = (MemRead | MemWrite) ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
        ram_addr       = idle ? req_idx : idx_q;
        total_lat      = CNT_W'(LAT) + CNT_W'(extra_lat);
    end

    mem_word_ram #(
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (store_acc),
        .strb   (Write_strb),
        .addr   (ram_addr),
        .wdata  (Write_data),
        .rdata  (ram_rdata),
        .peek_c (ram_peek)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        is_inst_d     = is_inst_q;
        inst_valid_d  = inst_valid_q;
        rd_valid_d    = rd_valid_q;
        instruction_d = instruction_q;
        read_data_d   = read_data_q;

        case (state_q)
            S_IDLE: begin
                if (load_acc || fetch_acc) begin
                    idx_d     = req_idx;
                    is_inst_d = fetch_acc;
                    // Single-cycle latency captures straight from the addressed word
                    if (total_lat == CNT_W'(1)) begin
                        cnt_d = '0;
                        if (fetch_acc) begin
                            state_d       = S_RESP_I;
                            inst_valid_d  = 1'b1;
                            instruction_d = ram_peek;
                        end else begin
                            state_d     = S_RESP_D;
                            rd_valid_d  = 1'b1;
                            read_data_d = ram_peek;
                        end
                    end else begin
                        cnt_d   = total_lat - CNT_W'(1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d = '0;
                    if (is_inst_q) begin
                        state_d       = S_RESP_I;
                        inst_valid_d  = 1'b1;
                        instruction_d = ram_rdata;
                    end else begin
                        state_d     = S_RESP_D;
                        rd_valid_d  = 1'b1;
                        read_data_d = ram_rdata;
                    end
                end
            end
            S_RESP_I: begin
                if (Inst_Ready) begin
                    state_d      = S_IDLE;
                    inst_valid_d = 1'b0;
                end
            end
            S_RESP_D: begin
                if (Read_data_Ready) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                inst_valid_d = 1'b0;
                rd_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            is_inst_q     <= 1'b0;
            inst_valid_q  <= 1'b0;
            rd_valid_q    <= 1'b0;
            instruction_q <= '0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            is_inst_q     <= is_inst_d;
            inst_valid_q  <= inst_valid_d;
            rd_valid_q    <= rd_valid_d;
            instruction_q <= instruction_d;
            read_data_q   <= read_data_d;
        end
    end

    assign Instruction     = instruction_q;
    assign Inst_Valid      = inst_valid_q;
    assign Read_data       = read_data_q;
    assign Read_data_Valid = rd_valid_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (default build, LAT=2, ADDR_WIDTH=12).
module tb_cpu_mem_responder;

    localparam int unsigned AW      = 12;
    localparam int unsigned LAT     = 2;
    localparam int          MAX_WAIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_mem_responder #(
        .ADDR_WIDTH (AW),
        .LAT        (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_STORE, OP_LOAD, OP_FETCH} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PC = '0; Inst_Req_Valid = 0; Inst_Ready = 0;
        Address = '0; MemWrite = 0; Write_data = '0; Write_strb = '0;
        MemRead = 0; Read_data_Ready = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        Address = a; Write_data = d; Write_strb = s; MemWrite = 1;
        #1;
        chk("store_mem_ready", 32'(Mem_Req_Ready), 32'd1);
        chk("store_blocks_fetch", 32'(Inst_Req_Ready), 32'd0);
        step();
        MemWrite = 0; Write_strb = '0;
    endtask

    // After the acceptance edge, count edges until the response valid appears
    task automatic wait_valid(input bit is_inst, output int lat);
        lat = 1;
        while (!(is_inst ? Inst_Valid : Read_data_Valid) && lat < MAX_WAIT) begin
            step();
            lat++;
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string name);
        int lat;
        Address = a; MemRead = 1;
        #1;
        chk({name, "_ready"}, 32'(Mem_Req_Ready), 32'd1);
        step();
        MemRead = 0;
        wait_valid(1'b0, lat);
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_data"}, Read_data, exp);
        Read_data_Ready = 1;
        step();
        Read_data_Ready = 0;
        #1;
        chk({name, "_valid_clear"}, 32'(Read_data_Valid), 32'd0);
        chk({name, "_idle_ready"}, 32'(Mem_Req_Ready), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input string name);
        int lat;
        PC = a; Inst_Req_Valid = 1;
        #1;
        chk({name, "_ready"}, 32'(Inst_Req_Ready), 32'd1);
        step();
        Inst_Req_Valid = 0;
        wait_valid(1'b1, lat);
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_data"}, Instruction, exp);
        Inst_Ready = 1;
        step();
        Inst_Ready = 0;
        #1;
        chk({name, "_valid_clear"}, 32'(Inst_Valid), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int  lat;
        bit  rose;

        vecs[0]  = '{OP_STORE, 32'h0000_0000, 32'h0000_0013, 4'hF, 32'h0};
        vecs[1]  = '{OP_FETCH, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0013};
        vecs[2]  = '{OP_STORE, 32'h0000_0104, 32'h1122_3344, 4'hF, 32'h0};
        vecs[3]  = '{OP_STORE, 32'h0000_0104, 32'h0000_AB00, 4'h2, 32'h0};
        vecs[4]  = '{OP_LOAD,  32'h0000_0104, 32'h0,         4'h0, 32'h1122_AB44};
        vecs[5]  = '{OP_STORE, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[6]  = '{OP_LOAD,  32'h0000_4000, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[7]  = '{OP_FETCH, 32'h0000_4002, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[8]  = '{OP_STORE, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[9]  = '{OP_STORE, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'h0};
        vecs[10] = '{OP_LOAD,  32'h0000_0008, 32'h0,         4'h0, 32'hFFFF_FFFF};
        vecs[11] = '{OP_STORE, 32'h0000_0008, 32'h1234_5678, 4'h9, 32'h0};
        vecs[12] = '{OP_LOAD,  32'h0000_0008, 32'h0,         4'h0, 32'h12FF_FF78};
        vecs[13] = '{OP_FETCH, 32'h0000_0104, 32'h0,         4'h0, 32'h1122_AB44};

        clear_inputs();
        rst = 1;
        step();
        #1;
        chk("rst_mem_ready", 32'(Mem_Req_Ready), 32'd0);
        chk("rst_inst_ready", 32'(Inst_Req_Ready), 32'd0);
        step();
        rst = 0;
        #1;
        chk("rst_inst_valid", 32'(Inst_Valid), 32'd0);
        chk("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
        chk("rst_instruction", Instruction, 32'h0);
        chk("rst_read_data", Read_data, 32'h0);
        chk("idle_mem_ready", 32'(Mem_Req_Ready), 32'd1);
        chk("idle_inst_ready", 32'(Inst_Req_Ready), 32'd1);

        // Response readies asserted with nothing pending must not produce anything
        Inst_Ready = 1; Read_data_Ready = 1;
        step(); step();
        chk("stray_ready_inst_valid", 32'(Inst_Valid), 32'd0);
        chk("stray_ready_rd_valid", 32'(Read_data_Valid), 32'd0);
        chk("stray_ready_idle", 32'(Mem_Req_Ready), 32'd1);
        Inst_Ready = 0; Read_data_Ready = 0;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_STORE: do_store(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
                OP_LOAD:  do_load(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_load", i));
                default:  do_fetch(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_fetch", i));
            endcase
        end

        // Response held while the CPU stalls
        Address = 32'h104; MemRead = 1;
        step();
        MemRead = 0;
        wait_valid(1'b0, lat);
        chk("hold_latency", 32'(lat), 32'(LAT));
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", 32'(Read_data_Valid), 32'd1);
            chk("hold_data", Read_data, 32'h1122_AB44);
            chk("hold_no_ready", 32'(Mem_Req_Ready), 32'd0);
        end
        Read_data_Ready = 1;
        step();
        Read_data_Ready = 0;
        #1;
        chk("hold_release_valid", 32'(Read_data_Valid), 32'd0);
        chk("hold_release_idle", 32'(Mem_Req_Ready), 32'd1);

        // Simultaneous load and fetch: load wins, fetch follows the data handshake
        Address = 32'h8; MemRead = 1; PC = 32'h104; Inst_Req_Valid = 1;
        #1;
        chk("prio_inst_ready", 32'(Inst_Req_Ready), 32'd0);
        chk("prio_mem_ready", 32'(Mem_Req_Ready), 32'd1);
        step();
        MemRead = 0;
        #1;
        chk("prio_wait_inst_ready", 32'(Inst_Req_Ready), 32'd0);
        wait_valid(1'b0, lat);
        chk("prio_load_latency", 32'(lat), 32'(LAT));
        chk("prio_load_data", Read_data, 32'h12FF_FF78);
        chk("prio_no_inst_valid", 32'(Inst_Valid), 32'd0);
        Read_data_Ready = 1;
        step();
        Read_data_Ready = 0;
        #1;
        chk("prio_fetch_ready", 32'(Inst_Req_Ready), 32'd1);
        step();
        Inst_Req_Valid = 0;
        wait_valid(1'b1, lat);
        chk("prio_fetch_latency", 32'(lat), 32'(LAT));
        chk("prio_fetch_data", Instruction, 32'h1122_AB44);
        Inst_Ready = 1;
        step();
        Inst_Ready = 0;
        #1;
        chk("prio_fetch_clear", 32'(Inst_Valid), 32'd0);

        // Reset while the read is counting down discards it
        Address = 32'h0; MemRead = 1;
        step();
        MemRead = 0;
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("mid_rst_rd_valid", 32'(Read_data_Valid), 32'd0);
        chk("mid_rst_idle", 32'(Mem_Req_Ready), 32'd1);
        rose = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (Read_data_Valid) rose = 1;
        end
        chk("mid_rst_never_valid", 32'(rose), 32'd0);
        do_load(32'h0, 32'hDEAD_BEEF, "post_rst_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
